// File: rtl/console_uart_tx.sv
// Memory-mapped console UART transmitter (8N1) with a status register at BASE_ADDRESS+4.
// Define CONSOLE_UART_TX_FIFO_EN for a FIFO_DEPTH-entry TX FIFO; otherwise a single holding register.
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (line low)
// DATA  | eight data bits, LSB first
// STOP  | stop bit (line high), then next byte or IDLE
`timescale 1ns/1ps

`ifndef READ
`define READ 1'b0
`endif
`ifndef WRITE
`define WRITE 1'b1
`endif

module console_uart_tx #(
    parameter logic [31:0] BASE_ADDRESS = 32'h1000_0000,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_memory_interface_enable,
    input  logic        data_memory_interface_state,
    input  logic [31:0] data_memory_interface_address,
    input  logic [3:0]  data_memory_interface_frame_mask,
    input  logic [31:0] data_memory_interface_write_data,
    output logic [31:0] data_memory_interface_read_data,
    output logic        uart_tx
);

    localparam logic [31:0] STATUS_ADDRESS = BASE_ADDRESS + 32'd4;
    localparam logic [15:0] BIT_RELOAD     = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_e;

    logic       push_req;
    logic       clear_req;
    logic       status_rd;
    logic       push_ok;
    logic       pop;
    logic       fifo_empty;
    logic       fifo_full;
    logic [7:0] fifo_head;
    logic       busy;
    logic       unused_bits;

    assign push_req  = data_memory_interface_enable
                    && (data_memory_interface_state == `WRITE)
                    && (data_memory_interface_address == BASE_ADDRESS)
                    && data_memory_interface_frame_mask[3];
    assign clear_req = data_memory_interface_enable
                    && (data_memory_interface_state == `WRITE)
                    && (data_memory_interface_address == STATUS_ADDRESS)
                    && data_memory_interface_frame_mask[3]
                    && data_memory_interface_write_data[2];
    assign status_rd = data_memory_interface_enable
                    && (data_memory_interface_state == `READ)
                    && (data_memory_interface_address == STATUS_ADDRESS);

    // A full buffer still takes a byte when the transmitter drains one on the same edge.
    assign push_ok = push_req && (!fifo_full || pop);

    assign unused_bits = ^{data_memory_interface_write_data[31:8],
                           data_memory_interface_frame_mask[2:0]};

`ifdef CONSOLE_UART_TX_FIFO_EN
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [7:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_COUNT);
    assign fifo_head  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = data_memory_interface_write_data[7:0];
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
`else
    logic [7:0] hold_q, hold_d;
    logic       hold_valid_q, hold_valid_d;

    assign fifo_empty = !hold_valid_q;
    assign fifo_full  = hold_valid_q;
    assign fifo_head  = hold_q;

    always_comb begin
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        if (pop) begin
            hold_valid_d = 1'b0;
        end
        if (push_ok) begin
            hold_d       = data_memory_interface_write_data[7:0];
            hold_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
        end
    end
`endif

    tx_state_e   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        overflow_q, overflow_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_head;
                    cnt_d   = BIT_RELOAD;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == '0) begin
                    cnt_d   = BIT_RELOAD;
                    bit_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (cnt_q == '0) begin
                    cnt_d   = BIT_RELOAD;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_STOP: begin
                if (cnt_q == '0) begin
                    // Back-to-back frames: the next start bit follows the stop bit directly.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_head;
                        cnt_d   = BIT_RELOAD;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase

        overflow_d = overflow_q;
        if (clear_req) begin
            overflow_d = 1'b0;
        end
        if (push_req && !push_ok) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy    = (state_q != ST_IDLE) || !fifo_empty;
    assign uart_tx = tx_q;
    assign data_memory_interface_read_data = status_rd
        ? {29'd0, overflow_q, fifo_full, busy}
        : 32'd0;

endmodule

// File: tb/tb_console_uart_tx.sv
// Bench for console_uart_tx: queue-based line model compared every cycle, plus literal scenario checks.
`timescale 1ns/1ps

`ifndef READ
`define READ 1'b0
`endif
`ifndef WRITE
`define WRITE 1'b1
`endif

module tb_console_uart_tx;

    localparam int          CPB  = 4;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] STAT = 32'h1000_0004;
`ifdef CONSOLE_UART_TX_FIFO_EN
    localparam int MDEPTH    = 8;
    localparam bit FIFO_MODE = 1'b1;
`else
    localparam int MDEPTH    = 1;
    localparam bit FIFO_MODE = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        st;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        tx;

    int checks = 0;
    int errors = 0;

    console_uart_tx #(
        .BASE_ADDRESS(BASE),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH(8)
    ) dut (
        .clk(clk),
        .reset(rst_n),
        .data_memory_interface_enable(en),
        .data_memory_interface_state(st),
        .data_memory_interface_address(addr),
        .data_memory_interface_frame_mask(mask),
        .data_memory_interface_write_data(wdata),
        .data_memory_interface_read_data(rdata),
        .uart_tx(tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a queue of pending bytes and the frame currently on the line.
    byte unsigned mq[$];
    bit           m_active;
    int           m_elapsed;
    logic [7:0]   m_byte;
    bit           m_ovf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_active  = 1'b0;
            m_elapsed = 0;
            m_byte    = 8'd0;
            m_ovf     = 1'b0;
        end else begin
            if (m_active) begin
                m_elapsed++;
                if (m_elapsed == 10 * CPB) begin
                    if (mq.size() > 0) begin
                        m_byte    = mq.pop_front();
                        m_elapsed = 0;
                    end else begin
                        m_active = 1'b0;
                    end
                end
            end else if (mq.size() > 0) begin
                m_byte    = mq.pop_front();
                m_active  = 1'b1;
                m_elapsed = 0;
            end
            if (en && st == `WRITE && addr == STAT && mask[3] && wdata[2])
                m_ovf = 1'b0;
            if (en && st == `WRITE && addr == BASE && mask[3]) begin
                if (mq.size() < MDEPTH) mq.push_back(wdata[7:0]);
                else m_ovf = 1'b1;
            end
        end
    end

    function automatic logic exp_tx();
        int idx;
        if (!m_active) return 1'b1;
        idx = m_elapsed / CPB;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return m_byte[idx-1];
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_rd();
        logic busy_e;
        logic full_e;
        if (!(en && st == `READ && addr == STAT)) return 32'd0;
        busy_e = m_active || (mq.size() > 0);
        full_e = (mq.size() == MDEPTH);
        return {29'd0, m_ovf, full_e, busy_e};
    endfunction

    bit cmp_en = 1'b0;
    always @(negedge clk) begin
        if (cmp_en) begin
            check("line", {31'd0, tx}, {31'd0, exp_tx()});
            check("read_data", rdata, exp_rd());
        end
    end

    // Line receiver: decodes frames from uart_tx by mid-bit sampling.
    byte unsigned rxq[$];
    bit           rx_busy = 1'b0;
    int           rx_cnt  = 0;
    logic [7:0]   rx_sh;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_busy = 1'b0;
            rx_cnt  = 0;
        end else if (!rx_busy) begin
            if (tx == 1'b0) begin
                rx_busy = 1'b1;
                rx_cnt  = 0;
            end
        end else begin
            rx_cnt++;
            if ((rx_cnt % CPB) == CPB / 2 && rx_cnt / CPB >= 1 && rx_cnt / CPB <= 8)
                rx_sh[rx_cnt / CPB - 1] = tx;
            if (rx_cnt == 10 * CPB - 1) begin
                rxq.push_back(rx_sh);
                rx_busy = 1'b0;
            end
        end
    end

    task automatic bus(input logic s, input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
        en = 1'b1; st = s; addr = a; mask = m; wdata = d;
        @(posedge clk); #1;
        en = 1'b0; st = 1'b0; addr = 32'd0; mask = 4'd0; wdata = 32'd0;
    endtask

    task automatic push(input logic [7:0] b);
        bus(`WRITE, BASE, 4'b1000, {24'hA5C3E7, b});
    endtask

    task automatic read_status(output logic [31:0] v);
        en = 1'b1; st = `READ; addr = STAT; mask = 4'd0;
        @(negedge clk);
        v = rdata;
        @(posedge clk); #1;
        en = 1'b0; addr = 32'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int limit);
        int k = 0;
        while ((m_active || mq.size() > 0) && k < limit) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= limit) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=busy required=idle after %0d cycles", limit);
        end
        idle(3);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] v;
        logic [9:0]  pat;
        byte unsigned exp_q[$];
        int r;

        rst_n = 1'b0; en = 1'b0; st = 1'b0; addr = 32'd0; mask = 4'd0; wdata = 32'd0;
        idle(3);
        check("reset_tx", {31'd0, tx}, 32'd1);
        en = 1'b1; st = `READ; addr = STAT; #1;
        check("reset_status", rdata, 32'd0);
        en = 1'b0; addr = 32'd0;
        idle(1);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // 0x41 pushed on the first edge after reset release.
        push(8'h41);
        check("pre_start_tx", {31'd0, tx}, 32'd1);
        idle(1);
        pat = 10'b0100000101;
        for (int i = 0; i < 10 * CPB; i++) begin
            check("frame_41", {31'd0, tx}, {31'd0, pat[9 - i / CPB]});
            idle(1);
        end
        read_status(v);
        check("status_after_41", v, 32'd0);
        idle(2);
        check("rx_41_count", rxq.size(), 32'd1);
        if (rxq.size() > 0) check("rx_41", {24'd0, rxq[0]}, 32'h41);

        // Burst of ten back-to-back pushes.
        rxq.delete();
        for (int b = 8'h30; b <= 8'h39; b++) push(8'(b));
        idle(10);
        read_status(v);
        check("status_burst", v, 32'h7);
        wait_idle(3000);
        exp_q.delete();
        if (FIFO_MODE) for (int b = 8'h30; b <= 8'h38; b++) exp_q.push_back(8'(b));
        else begin exp_q.push_back(8'h30); exp_q.push_back(8'h31); end
        check("rx_burst_count", rxq.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rxq.size(); i++)
            check("rx_burst", {24'd0, rxq[i]}, {24'd0, exp_q[i]});

        // Overflow clear and base-address read.
        read_status(v);
        check("status_ovf", v, 32'h4);
        bus(`WRITE, STAT, 4'b1000, 32'h4);
        read_status(v);
        check("status_cleared", v, 32'h0);
        en = 1'b1; st = `READ; addr = BASE;
        @(negedge clk);
        check("read_base", rdata, 32'd0);
        @(posedge clk); #1;
        en = 1'b0; addr = 32'd0;

        // Ignored writes.
        rxq.delete();
        bus(`WRITE, BASE, 4'b0100, 32'h5A);
        bus(`WRITE, 32'h1000_0008, 4'b1000, 32'h5A);
        idle(20);
        check("ignored_tx", {31'd0, tx}, 32'd1);
        read_status(v);
        check("ignored_status", v, 32'h0);
        check("ignored_rx", rxq.size(), 32'd0);

        // Pushes during an active frame.
        rxq.delete();
        push(8'h55);
        idle(8);
        push(8'h66);
        idle(4);
        push(8'h77);
        wait_idle(3000);
        exp_q.delete();
        exp_q.push_back(8'h55); exp_q.push_back(8'h66);
        if (FIFO_MODE) exp_q.push_back(8'h77);
        check("rx_hold_count", rxq.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rxq.size(); i++)
            check("rx_hold", {24'd0, rxq[i]}, {24'd0, exp_q[i]});
        read_status(v);
        check("status_hold", v, FIFO_MODE ? 32'h0 : 32'h4);
        bus(`WRITE, STAT, 4'b1000, 32'h4);

        // Reset in the middle of a data bit.
        rxq.delete();
        push(8'hC3);
        idle(1 + CPB + 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("midframe_reset_tx", {31'd0, tx}, 32'd1);
        en = 1'b1; st = `READ; addr = STAT; #1;
        check("midframe_reset_status", rdata, 32'd0);
        en = 1'b0; addr = 32'd0;
        idle(2);
        rst_n = 1'b1;
        idle(60);
        check("no_resume_rx", rxq.size(), 32'd0);
        read_status(v);
        check("no_resume_status", v, 32'd0);

        // Random traffic against the model.
        for (int it = 0; it < 2500; it++) begin
            r = $urandom_range(0, 99);
            if (r < 50) begin
                bus(`WRITE,
                    ($urandom_range(0, 9) == 0) ? 32'h1000_0008 : BASE,
                    ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b1000,
                    $urandom);
            end else if (r < 58) begin
                bus(`WRITE, STAT, 4'($urandom), $urandom);
            end else if (r < 70) begin
                read_status(v);
            end else if (r < 75) begin
                bus(`READ, BASE, 4'b1111, 32'd0);
            end else begin
                idle($urandom_range(1, 25));
            end
        end
        wait_idle(5000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
